// File: rtl/cap_touch_scanner.sv
// cap_touch_scanner: charge-time scanner for capacitive pads with per-pad debounce and press pulses.
// Ports:
//   clk_i                 system clock, rising edge
//   rst_ni                asynchronous active-low reset
//   enable_i              scanning enable, sampled when a scan starts
//   capacitive_sensors_i  raw asynchronous pad levels
//   capacitive_sensors_o  shared charge drive (0 discharge, 1 charge)
//   touch_state_o         debounced touched flags
//   touch_pulse_o         one-cycle pulse on a debounced press
//   scan_done_o           one-cycle pulse when scan results are published
//   count_sel_i           pad index for count readback
//   count_out_o           published charge count of the selected pad, 0 when out of range
module cap_touch_scanner #(
  parameter int NUM_SENSORS      = 9,
  parameter int CNT_W            = 16,
  parameter int DISCHARGE_CYCLES = 64,
  parameter int TIMEOUT          = 4095,
  parameter int THRESHOLD        = 200,
  parameter int DEBOUNCE         = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [NUM_SENSORS-1:0] capacitive_sensors_i,
  output logic                   capacitive_sensors_o,
  output logic [NUM_SENSORS-1:0] touch_state_o,
  output logic [NUM_SENSORS-1:0] touch_pulse_o,
  output logic                   scan_done_o,
  input  logic [3:0]             count_sel_i,
  output logic [CNT_W-1:0]       count_out_o
);
  localparam logic [2:0] IDLE = 3'd0, DISCHARGE = 3'd1, CHARGE = 3'd2, EVAL = 3'd3, PUBLISH = 3'd4;
  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);
  localparam logic [2:0] DEB = 3'(DEBOUNCE);

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0] meta_q, sync_q;
  logic [NUM_SENSORS-1:0] cap_q, cap_d;
  logic [NUM_SENSORS-1:0] touch_q, touch_d;
  logic [NUM_SENSORS-1:0] pulse_q, pulse_d;
  logic [NUM_SENSORS-1:0] raw;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       work_q [NUM_SENSORS];
  logic [CNT_W-1:0]       work_d [NUM_SENSORS];
  logic [CNT_W-1:0]       pub_q [NUM_SENSORS];
  logic [CNT_W-1:0]       pub_d [NUM_SENSORS];
  logic [2:0]             agree_q [NUM_SENSORS];
  logic [2:0]             agree_d [NUM_SENSORS];

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_SENSORS; i++) raw[i] = work_q[i] > THR;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    touch_d = touch_q;
    pulse_d = '0;
    done_d  = 1'b0;
    work_d  = work_q;
    pub_d   = pub_q;
    agree_d = agree_q;
    case (state_q)
      IDLE: begin
        state_d = enable_i ? DISCHARGE : IDLE;
        cnt_d   = '0;
      end
      DISCHARGE: begin
        state_d = cnt_q == DIS_LAST ? CHARGE : DISCHARGE;
        cnt_d   = cnt_q == DIS_LAST ? '0 : cnt_q + 1'b1;
      end
      CHARGE: begin
        cnt_d = cnt_q + 1'b1;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          if (sync_q[i] && !cap_q[i]) begin
            cap_d[i]  = 1'b1;
            work_d[i] = cnt_q;
          end
        end
        // Exit decision uses the flags including this cycle's captures.
        if (&cap_d || cnt_q == TMO) begin
          state_d = EVAL;
          cnt_d   = '0;
          for (int i = 0; i < NUM_SENSORS; i++) if (!cap_d[i]) work_d[i] = TMO;
        end
      end
      EVAL: begin
        // Results land in the output registers here so they all appear during PUBLISH.
        state_d = PUBLISH;
        done_d  = 1'b1;
        pub_d   = work_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
          agree_d[i] = raw[i] != touch_q[i] ? agree_q[i] + 3'd1 : 3'd0;
          if (agree_d[i] == DEB) begin
            touch_d[i] = raw[i];
            pulse_d[i] = raw[i];
            agree_d[i] = 3'd0;
          end
        end
      end
      PUBLISH: begin
        cap_d   = '0;
        cnt_d   = '0;
        state_d = enable_i ? DISCHARGE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      meta_q  <= '0;
      sync_q  <= '0;
      cap_q   <= '0;
      touch_q <= '0;
      pulse_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
        work_q[i]  <= '0;
        pub_q[i]   <= '0;
        agree_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      meta_q  <= capacitive_sensors_i;
      sync_q  <= meta_q;
      cap_q   <= cap_d;
      touch_q <= touch_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      work_q  <= work_d;
      pub_q   <= pub_d;
      agree_q <= agree_d;
    end
  end

  // Drive decodes the state register, so the async reset drops it immediately.
  assign capacitive_sensors_o = state_q == CHARGE;
  assign touch_state_o        = touch_q;
  assign touch_pulse_o        = pulse_q;
  assign scan_done_o          = done_q;
  assign count_out_o          = 32'(count_sel_i) < NUM_SENSORS ? pub_q[count_sel_i] : '0;
endmodule

// File: tb/tb_cap_touch_scanner.sv
// tb_cap_touch_scanner: table-driven and randomized bench for cap_touch_scanner with a charge-time pad model.
`timescale 1ns/1ps
module tb_cap_touch_scanner;
  localparam int N = 9, W = 16, DC = 4, TO = 63, TH = 20, DEB = 2;
  localparam int SLOW = 30, FAST = 5, NEVER = -1, ALWAYS = -2;

  logic clk = 1'b0;
  logic rst_n, enable;
  logic [N-1:0] pads;
  logic drive, done;
  logic [N-1:0] ts, tp;
  logic [3:0] sel;
  logic [W-1:0] cnt_out;

  int tests = 0, fails = 0;
  int dly [N];
  int cyc = 0, last_done = 0;
  int mcnt [N];
  int magree [N];
  int mper;
  logic [N-1:0] mstate, mpulse;

  typedef struct {
    logic [N-1:0] slow;
    logic [N-1:0] never;
    logic [N-1:0] ts;
    logic [N-1:0] tp;
    logic [3:0]   sel;
    int           cnt;
    int           per;
  } row_t;
  row_t rows [16];

  cap_touch_scanner #(
    .NUM_SENSORS(N), .CNT_W(W), .DISCHARGE_CYCLES(DC),
    .TIMEOUT(TO), .THRESHOLD(TH), .DEBOUNCE(DEB)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .capacitive_sensors_i(pads), .capacitive_sensors_o(drive),
    .touch_state_o(ts), .touch_pulse_o(tp), .scan_done_o(done),
    .count_sel_i(sel), .count_out_o(cnt_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pad i reads high dly[i] cycles after the drive first reads high.
  initial begin : pad_drv
    int t;
    logic was;
    t = 0;
    was = 1'b0;
    pads = '0;
    forever begin
      @(posedge clk);
      #1;
      t = drive ? (was ? t + 1 : 0) : 0;
      was = drive;
      for (int i = 0; i < N; i++)
        pads[i] = (dly[i] == ALWAYS) || (drive && dly[i] >= 0 && t >= dly[i]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mstate = '0;
    mpulse = '0;
    for (int i = 0; i < N; i++) magree[i] = 0;
  endtask

  // Expected counts: synchronizer adds 2, stuck-high reads 0, never-high saturates at TO.
  task automatic model_scan();
    int mx;
    logic r;
    mx = 0;
    mpulse = '0;
    for (int i = 0; i < N; i++) begin
      mcnt[i] = dly[i] == ALWAYS ? 0 : dly[i] == NEVER ? TO : (dly[i] + 2 > TO ? TO : dly[i] + 2);
      if (mcnt[i] > mx) mx = mcnt[i];
    end
    mper = DC + mx + 1 + 2;
    for (int i = 0; i < N; i++) begin
      r = mcnt[i] > TH;
      if (r != mstate[i]) begin
        magree[i]++;
        if (magree[i] >= DEB) begin
          mstate[i] = r;
          mpulse[i] = r;
          magree[i] = 0;
        end
      end else magree[i] = 0;
    end
  endtask

  task automatic do_scan(input string tag, output int per);
    bit ok;
    ok = 1'b0;
    model_scan();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " scan_done seen"}, 32'(ok), 32'd1);
    per = cyc - last_done;
    last_done = cyc;
  endtask

  task automatic wait_drive(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (drive) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " drive high seen"}, 32'(ok), 32'd1);
  endtask

  task automatic set_all(input int d);
    for (int i = 0; i < N; i++) dly[i] = d;
  endtask

  initial begin
    int per, dn, dh, r;
    rows[0]  = '{9'h000, 9'h000, 9'h000, 9'h000, 4'd0, 7, 0};
    rows[1]  = '{9'h000, 9'h000, 9'h000, 9'h000, 4'd0, 7, 14};
    rows[2]  = '{9'h008, 9'h000, 9'h000, 9'h000, 4'd3, 32, 39};
    rows[3]  = '{9'h008, 9'h000, 9'h008, 9'h008, 4'd3, 32, 39};
    rows[4]  = '{9'h000, 9'h000, 9'h008, 9'h000, 4'd3, 7, 14};
    rows[5]  = '{9'h008, 9'h000, 9'h008, 9'h000, 4'd3, 32, 39};
    rows[6]  = '{9'h000, 9'h000, 9'h008, 9'h000, 4'd3, 7, 14};
    rows[7]  = '{9'h000, 9'h000, 9'h000, 9'h000, 4'd3, 7, 14};
    rows[8]  = '{9'h008, 9'h000, 9'h000, 9'h000, 4'd3, 32, 39};
    rows[9]  = '{9'h000, 9'h000, 9'h000, 9'h000, 4'd3, 7, 14};
    rows[10] = '{9'h008, 9'h000, 9'h000, 9'h000, 4'd3, 32, 39};
    rows[11] = '{9'h000, 9'h000, 9'h000, 9'h000, 4'd3, 7, 14};
    rows[12] = '{9'h000, 9'h100, 9'h000, 9'h000, 4'd8, 63, 70};
    rows[13] = '{9'h000, 9'h100, 9'h100, 9'h100, 4'd8, 63, 70};
    rows[14] = '{9'h000, 9'h000, 9'h100, 9'h000, 4'd8, 7, 14};
    rows[15] = '{9'h000, 9'h000, 9'h000, 9'h000, 4'd8, 7, 14};

    rst_n = 1'b0;
    enable = 1'b0;
    sel = 4'd0;
    set_all(FAST);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset drive", 32'(drive), 32'd0);
    check("reset touch_state", 32'(ts), 32'd0);
    check("reset touch_pulse", 32'(tp), 32'd0);
    check("reset scan_done", 32'(done), 32'd0);
    check("reset count_out", 32'(cnt_out), 32'd0);
    rst_n = 1'b1;
    enable = 1'b1;

    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++)
        dly[i] = rows[k].never[i] ? NEVER : rows[k].slow[i] ? SLOW : FAST;
      do_scan($sformatf("row%0d", k), per);
      check($sformatf("row%0d touch_state", k), 32'(ts), 32'(rows[k].ts));
      check($sformatf("row%0d touch_pulse", k), 32'(tp), 32'(rows[k].tp));
      if (k > 0) check($sformatf("row%0d scan period", k), 32'(per), 32'(rows[k].per));
      sel = rows[k].sel;
      #1;
      check($sformatf("row%0d count_out sel=%0d", k, rows[k].sel), 32'(cnt_out), 32'(rows[k].cnt));
      @(negedge clk);
      check($sformatf("row%0d scan_done width", k), 32'(done), 32'd0);
      check($sformatf("row%0d touch_pulse width", k), 32'(tp), 32'd0);
    end

    for (int s = 9; s < 16; s++) begin
      sel = 4'(s);
      #1;
      check($sformatf("readback sel=%0d", s), 32'(cnt_out), 32'd0);
    end
    sel = 4'd0;
    #1;
    check("readback sel=0", 32'(cnt_out), 32'd7);
    do_scan("settle", per);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin
        r = int'($urandom_range(0, 19));
        dly[i] = r == 0 ? NEVER : r == 1 ? ALWAYS : r == 2 ? int'($urandom_range(55, 70)) : int'($urandom_range(0, 40));
      end
      do_scan($sformatf("rnd%0d", k), per);
      check($sformatf("rnd%0d touch_state", k), 32'(ts), 32'(mstate));
      check($sformatf("rnd%0d touch_pulse", k), 32'(tp), 32'(mpulse));
      check($sformatf("rnd%0d scan period", k), 32'(per), 32'(mper));
      for (int i = 0; i < N; i++) begin
        sel = 4'(i);
        #1;
        check($sformatf("rnd%0d count pad%0d", k, i), 32'(cnt_out), 32'(mcnt[i]));
      end
      @(negedge clk);
      check($sformatf("rnd%0d touch_pulse width", k), 32'(tp), 32'd0);
    end

    set_all(FAST);
    wait_drive("enable drop");
    model_scan();
    repeat (2) @(negedge clk);
    enable = 1'b0;
    dn = 0;
    dh = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        last_done = cyc;
      end
      if (k > 25 && drive) dh++;
    end
    check("enable drop scan_done count", 32'(dn), 32'd1);
    check("enable drop idle drive", 32'(dh), 32'd0);
    check("enable drop touch_state", 32'(ts), 32'(mstate));

    enable = 1'b1;
    set_all(FAST);
    dly[0] = SLOW;
    do_scan("pad0 slow a", per);
    check("pad0 slow a touch_state", 32'(ts), 32'(mstate));
    do_scan("pad0 slow b", per);
    check("pad0 slow b touch_state", 32'(ts), 32'(mstate));
    check("pad0 slow b touch_pulse", 32'(tp), 32'(mpulse));

    wait_drive("reset test");
    repeat (3) @(negedge clk);
    sel = 4'd0;
    #1;
    check("pre-reset touch_state", 32'(ts), 32'(mstate));
    check("pre-reset count_out", 32'(cnt_out), 32'd32);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset drive", 32'(drive), 32'd0);
    check("async reset touch_state", 32'(ts), 32'd0);
    check("async reset touch_pulse", 32'(tp), 32'd0);
    check("async reset scan_done", 32'(done), 32'd0);
    check("async reset count_out", 32'(cnt_out), 32'd0);
    model_reset();
    set_all(FAST);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_scan("post reset", per);
    check("post reset touch_state", 32'(ts), 32'd0);
    #1;
    check("post reset count_out", 32'(cnt_out), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cap_touch_scanner.md
# cap_touch_scanner

Front-end scanner between the nine capacitive mole pads and the processor's sensor input. It repeatedly discharges the pads and then drives the shared charge line high, timing how long each pad takes to read high. Slow pads (extra finger capacitance) are classified as touched. The per-pad results are debounced and presented to the processor as a stable 9-bit touch vector, plus one-cycle new-press pulses.

## Interface
- NUM_SENSORS, 9, number of pads/inputs
- CNT_W, 16, charge-time counter width
- DISCHARGE_CYCLES, 64, cycles the charge line is held low before each measurement (≥1)
- TIMEOUT, 4095, maximum charge count; pads not high by then record TIMEOUT (< 2^CNT_W)
- THRESHOLD, 200, a pad is raw-touched when its count > THRESHOLD
- DEBOUNCE, 3, consecutive agreeing scans required to change a pad's stable state (1..7)
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  scanning enabled; sampled at scan start only
- capacitive_sensors_in  in  NUM_SENSORS  raw asynchronous pad inputs
- capacitive_sensors_out  out  1  shared charge drive (0 = discharge, 1 = charge)
- touch_state  out  NUM_SENSORS  debounced touched flags
- touch_pulse  out  NUM_SENSORS  one-cycle pulse on debounced 0→1 per pad
- scan_done  out  1  one-cycle pulse when a scan's results are published
- count_sel  in  4  pad index for count readback
- count_out  out  CNT_W  last published charge count of pad count_sel; 0 if count_sel ≥ NUM_SENSORS

## Operation
- Every capacitive_sensors_in bit passes through a 2-flop synchronizer. Only synced values are used.
- FSM states: IDLE, DISCHARGE, CHARGE, EVAL, PUBLISH.
- IDLE: drive = 0. Moves to DISCHARGE when enable = 1.
- DISCHARGE: drive = 0. The counter counts 0..DISCHARGE_CYCLES-1, then the FSM goes to CHARGE with the counter cleared.
- CHARGE: drive = 1. The counter increments every cycle starting at 0.
  - Per pad: in the first cycle its synced bit = 1 and its captured flag is clear, the current counter value is stored and the flag is set.
  - Exit to EVAL when all flags are set, or when counter = TIMEOUT. In the timeout case, uncaptured pads store TIMEOUT.
- EVAL: drive = 0.
  - raw[i] = count[i] > THRESHOLD.
  - Per-pad 3-bit agree counter: if raw[i] ≠ touch_state[i], the counter increments; otherwise it clears.
  - On reaching DEBOUNCE, touch_state[i] toggles and the counter clears.
- PUBLISH (one cycle):
  - scan_done = 1. touch_pulse carries pads that rose in EVAL. The count_out bank is updated from the working counts. Captured flags are cleared.
  - Next state is DISCHARGE if enable = 1, else IDLE.
- Disabling enable mid-scan has no effect until PUBLISH. The current scan always completes.
- count_out is combinational from the published bank and count_sel.

## Timing
- Reset values: drive 0, touch_state 0, touch_pulse 0, scan_done 0, published counts 0, agree counters 0, state IDLE, synchronizers 0.
- Reset asserted mid-scan immediately forces drive low and all outputs to their reset values. After deassertion the FSM starts from IDLE.
- A pad edge arriving while counter = k in CHARGE is captured with count k+2, from synchronizer latency.
- A pad already synced-high in the first CHARGE cycle captures count 0 (never touched).
- Scan length = DISCHARGE_CYCLES + (charge cycles, last exit count + 1) + 1 EVAL + 1 PUBLISH.
- touch_state, touch_pulse, scan_done and count_out all change together, on the PUBLISH cycle's outputs.
- touch_pulse[i] is never high unless touch_state[i] is high in the same cycle.
- A release (1→0) produces no pulse.

## Test plan
Bench parameters: DISCHARGE_CYCLES=4, TIMEOUT=63, THRESHOLD=20, DEBOUNCE=2.
- **Untouched pads:** all pads rise 5 cycles after drive goes high.
  - Every count = 7.
  - touch_state stays 0.
  - scan_done every 4+8+2 = 14 cycles.
- **Press detection:** pad 3 rises 30 cycles after drive goes high, others at 5, for 2 scans.
  - First scan: count_out (sel=3) = 32, touch_state still 0.
  - Second scan's PUBLISH: touch_state = 9'h008 and touch_pulse = 9'h008 for exactly 1 cycle.
- **Debounce rejection:** pad 3 slow, then fast, alternating each scan.
  - touch_state[3] never sets.
  - No touch_pulse.
- **Timeout:** pad 8 held low forever, others rise at 5.
  - count(8) = 63.
  - CHARGE lasts 64 cycles.
  - After 2 scans touch_state = 9'h100.
  - A release (pad 8 fast for 2 scans) clears it with no pulse.
- **Enable and reset:**
  - Drop enable mid-CHARGE: the scan completes, scan_done pulses once, then the FSM idles with drive 0.
  - Assert reset mid-CHARGE: drive and all outputs go 0 asynchronously (before the next clock edge).
- **Count readback:** count_sel = 9..15 → count_out = 0. count_sel = 0 → count of pad 0 from the last scan.
